// File: rtl/timer_interrupt_unit_if.sv
`timescale 1ns/1ps
// Signal bundle between the timer flag/mask block, the CPU and the timer interrupt unit.
// The unit takes the slave view; the CPU/flag-register side takes the master view.
interface timer_interrupt_unit_if #(
  parameter int VEC_W = 16
);
  logic [7:0]       TIFR0_flags;
  logic [7:0]       TIMSK0_mask;
  logic [7:0]       TIFR1_flags;
  logic [7:0]       TIMSK1_mask;
  logic             global_int_enable;
  logic             irq_ack;
  logic             reti;
  logic             irq_req;
  logic [VEC_W-1:0] irq_vector;
  logic [1:0]       irq_source;
  logic [7:0]       TIFR0_hw_clear;
  logic [7:0]       TIFR1_hw_clear;
  logic             in_service;

  modport slave (
    input  TIFR0_flags, TIMSK0_mask, TIFR1_flags, TIMSK1_mask,
    input  global_int_enable, irq_ack, reti,
    output irq_req, irq_vector, irq_source,
    output TIFR0_hw_clear, TIFR1_hw_clear, in_service
  );

  modport master (
    output TIFR0_flags, TIMSK0_mask, TIFR1_flags, TIMSK1_mask,
    output global_int_enable, irq_ack, reti,
    input  irq_req, irq_vector, irq_source,
    input  TIFR0_hw_clear, TIFR1_hw_clear, in_service
  );
endinterface

// File: rtl/timer_interrupt_unit.sv
`timescale 1ns/1ps
// Timer interrupt request unit: picks the top-priority pending timer source, runs the
// req/ack handshake with the CPU, pulses the flag clear, and blocks nesting until RETI.
module timer_interrupt_unit #(
  parameter int VEC_W          = 16,
  parameter int HOLDOFF_CYCLES = 1
) (
  input  logic                  sysClock,
  input  logic                  system_reset,
  timer_interrupt_unit_if.slave bus
);
  localparam int CNT_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);

  localparam logic [1:0] SRC_T1COMP = 2'd0;
  localparam logic [1:0] SRC_T1OVF  = 2'd1;
  localparam logic [1:0] SRC_T0COMP = 2'd2;
  localparam logic [1:0] SRC_T0OVF  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQUEST,
    S_CLEAR,
    S_SERVICE,
    S_HOLDOFF
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       src_q, src_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             req_q, req_d;
  logic [7:0]       clr0_q, clr0_d;
  logic [7:0]       clr1_q, clr1_d;
  logic             serv_q, serv_d;

  logic [3:0] pending;
  logic [1:0] top_src;

  // pending[] is indexed by source code, so index 0 is also the highest priority.
  assign pending[SRC_T1COMP] = bus.TIFR1_flags[4] & bus.TIMSK1_mask[4];
  assign pending[SRC_T1OVF]  = bus.TIFR1_flags[0] & bus.TIMSK1_mask[0];
  assign pending[SRC_T0COMP] = bus.TIFR0_flags[1] & bus.TIMSK0_mask[1];
  assign pending[SRC_T0OVF]  = bus.TIFR0_flags[0] & bus.TIMSK0_mask[0];

  logic unused_flag_bits;
  assign unused_flag_bits = ^{bus.TIFR0_flags[7:2], bus.TIMSK0_mask[7:2],
                              bus.TIFR1_flags[7:5], bus.TIFR1_flags[3:1],
                              bus.TIMSK1_mask[7:5], bus.TIMSK1_mask[3:1]};

  function automatic logic [VEC_W-1:0] vec_of(input logic [1:0] src);
    case (src)
      SRC_T1COMP: vec_of = VEC_W'(12'h00E);
      SRC_T1OVF:  vec_of = VEC_W'(12'h012);
      SRC_T0COMP: vec_of = VEC_W'(12'h014);
      default:    vec_of = VEC_W'(12'h016);
    endcase
  endfunction

  always_comb begin
    top_src = SRC_T0OVF;
    for (int i = 3; i >= 0; i--) begin
      if (pending[i]) top_src = 2'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    vec_d   = vec_q;
    hold_d  = hold_q;
    case (state_q)
      S_IDLE: begin
        if (bus.global_int_enable && (|pending)) begin
          state_d = S_REQUEST;
          src_d   = top_src;
          vec_d   = vec_of(top_src);
        end
      end
      S_REQUEST: begin
        // Withdrawal wins over a simultaneous acknowledge.
        if (!pending[src_q] || !bus.global_int_enable) state_d = S_IDLE;
        else if (bus.irq_ack)                          state_d = S_CLEAR;
      end
      S_CLEAR: state_d = S_SERVICE;
      S_SERVICE: begin
        if (bus.reti) begin
          state_d = S_HOLDOFF;
          hold_d  = '0;
        end
      end
      S_HOLDOFF: begin
        if (hold_q == HOLD_LAST) state_d = S_IDLE;
        else                     hold_d  = hold_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they are registered alongside it.
    req_d  = (state_d == S_REQUEST);
    serv_d = (state_d == S_SERVICE);
    clr0_d = '0;
    clr1_d = '0;
    if (state_d == S_CLEAR) begin
      case (src_d)
        SRC_T1COMP: clr1_d[4] = 1'b1;
        SRC_T1OVF:  clr1_d[0] = 1'b1;
        SRC_T0COMP: clr0_d[1] = 1'b1;
        default:    clr0_d[0] = 1'b1;
      endcase
    end
  end

  always_ff @(posedge sysClock or negedge system_reset) begin
    if (!system_reset) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      vec_q   <= '0;
      hold_q  <= '0;
      req_q   <= 1'b0;
      clr0_q  <= '0;
      clr1_q  <= '0;
      serv_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      vec_q   <= vec_d;
      hold_q  <= hold_d;
      req_q   <= req_d;
      clr0_q  <= clr0_d;
      clr1_q  <= clr1_d;
      serv_q  <= serv_d;
    end
  end

  assign bus.irq_req        = req_q;
  assign bus.irq_vector     = vec_q;
  assign bus.irq_source     = src_q;
  assign bus.TIFR0_hw_clear = clr0_q;
  assign bus.TIFR1_hw_clear = clr1_q;
  assign bus.in_service     = serv_q;
endmodule
